led_show_controller: RTL and testbench

Sequencer for the 18-bit red LED bank on the DE2 board. It divides CLOCK_50 into a slow step tick and runs the LED datapath through a fixed rotation of display modes: bounce, fill, blink and binary count. The rotation auto-advances after a dwell count of ticks, or immediately on a next-mode request. It replaces a free-running single-pattern shifter as the block that owns LEDR.

---
 rtl/led_show_pkg.sv | 33 +++
 rtl/tick_prescaler.sv | 27 ++
 rtl/led_show_controller.sv | 140 ++++++++++++++
 tb/tb_led_show_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_show_pkg.sv
// Shared definitions for the LED show sequencer: mode encodings, blink masks
// and the mode rotation helper.
package led_show_pkg;

    // Display modes, in rotation order. COUNT wraps back to BOUNCE.
    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_FILL   = 2'd1;
    localparam logic [1:0] MODE_BLINK  = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    // Bounce direction.
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Widest LED bank the blink masks cover; users slice the low WIDTH bits.
    localparam int MASK_MAX_WIDTH = 64;

    // Alternating-bit mask: odd=0 lights bits 0,2,4,... and odd=1 lights bits 1,3,5,...
    function automatic logic [MASK_MAX_WIDTH-1:0] blink_mask(input logic odd);
        logic [MASK_MAX_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX_WIDTH; i++) begin
            m[i] = ((i % 2) == 1) ? odd : ~odd;
        end
        return m;
    endfunction

    // Next mode in the rotation; the 2-bit add wraps COUNT to BOUNCE.
    function automatic logic [1:0] next_mode(input logic [1:0] mode);
        return mode + 2'd1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle TICK every 2^DIV_BITS cycles.
// A clear restarts the count so the next TICK lands a full period later.
module tick_prescaler #(
    parameter int DIV_BITS = 24
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    output logic TICK
);

    localparam logic [DIV_BITS-1:0] COUNT_MAX = '1;

    logic [DIV_BITS-1:0] count_q;

    // Count every cycle and strobe TICK the cycle after the counter hits its maximum.
    always_ff @(posedge CLOCK_50) begin
        if (reset || clear) begin
            count_q <= '0;
            TICK    <= 1'b0;
        end else begin
            count_q <= count_q + DIV_BITS'(1);
            TICK    <= (count_q == COUNT_MAX);
        end
    end

endmodule

// File: rtl/led_show_controller.sv
// LED show sequencer for the red LED bank. Steps the LEDs on each slow tick
// through BOUNCE, FILL, BLINK and COUNT, moving to the next mode after DWELL
// ticks or on a KEY_NEXT rising edge.
module led_show_controller
    import led_show_pkg::*;
#(
    parameter int DIV_BITS = 24,
    parameter int WIDTH    = 18,  // 4..MASK_MAX_WIDTH
    parameter int DWELL    = 36   // at least 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             KEY_NEXT,
    input  logic             PAUSE,
    output logic [WIDTH-1:0] LEDR,
    output logic [1:0]       MODE,
    output logic             TICK
);

    // Wide enough to hold DWELL-1 even when DWELL is 1.
    localparam int DWELL_BITS = $clog2(DWELL + 1);
    localparam logic [DWELL_BITS-1:0] DWELL_LAST = DWELL_BITS'(DWELL - 1);

    localparam logic [MASK_MAX_WIDTH-1:0] EVEN_FULL = blink_mask(1'b0);
    localparam logic [MASK_MAX_WIDTH-1:0] ODD_FULL  = blink_mask(1'b1);
    localparam logic [WIDTH-1:0] EVEN_MASK = EVEN_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ODD_MASK  = ODD_FULL[WIDTH-1:0];

    logic                  key_q;
    logic                  dir_q;
    logic [DWELL_BITS-1:0] dwell_q;

    logic                  key_rise;
    logic                  step;
    logic                  expire;
    logic                  advance;
    logic [WIDTH-1:0]      step_led;
    logic                  step_dir;
    logic [WIDTH-1:0]      entry_led;

    tick_prescaler #(
        .DIV_BITS (DIV_BITS)
    ) u_tick_prescaler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clear    (advance),
        .TICK     (TICK)
    );

    // Step and advance qualification; a key edge and an expiry together still give one advance.
    always_comb begin
        key_rise = KEY_NEXT & ~key_q;
        step     = TICK & ~PAUSE;
        expire   = step && (dwell_q == DWELL_LAST);
        advance  = key_rise | expire;
    end

    // Pattern and bounce direction after one step in the current mode.
    always_comb begin
        step_led = LEDR;
        step_dir = dir_q;
        unique case (MODE)
            MODE_BOUNCE: begin
                if (dir_q == DIR_LEFT) begin
                    step_led = LEDR << 1;
                    // Turn around on the same step that lights the top bit.
                    if (step_led[WIDTH-1]) begin
                        step_dir = DIR_RIGHT;
                    end
                end else begin
                    step_led = LEDR >> 1;
                    if (step_led[0]) begin
                        step_dir = DIR_LEFT;
                    end
                end
            end
            MODE_FILL: begin
                step_led = (&LEDR) ? '0 : {LEDR[WIDTH-2:0], 1'b1};
            end
            MODE_BLINK: begin
                step_led = (LEDR == EVEN_MASK) ? ODD_MASK : EVEN_MASK;
            end
            MODE_COUNT: begin
                step_led = LEDR + WIDTH'(1);
            end
            default: begin
                step_led = LEDR;
            end
        endcase
    end

    // Entry pattern of the mode being advanced into.
    always_comb begin
        entry_led = '0;
        unique case (next_mode(MODE))
            MODE_BOUNCE: entry_led = WIDTH'(1);
            MODE_FILL:   entry_led = '0;
            MODE_BLINK:  entry_led = EVEN_MASK;
            MODE_COUNT:  entry_led = '0;
            default:     entry_led = '0;
        endcase
    end

    // KEY_NEXT history for rising-edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_q <= 1'b0;
        end else begin
            key_q <= KEY_NEXT;
        end
    end

    // Mode FSM, bounce direction and dwell count; an advance overrides any pending step.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            MODE    <= MODE_BOUNCE;
            dir_q   <= DIR_LEFT;
            dwell_q <= '0;
        end else if (advance) begin
            MODE    <= next_mode(MODE);
            dir_q   <= DIR_LEFT;
            dwell_q <= '0;
        end else if (step) begin
            dir_q   <= step_dir;
            dwell_q <= dwell_q + DWELL_BITS'(1);
        end
    end

    // LED datapath: entry value on an advance, otherwise the stepped pattern.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            LEDR <= WIDTH'(1);
        end else if (advance) begin
            LEDR <= entry_led;
        end else if (step) begin
            LEDR <= step_led;
        end
    end

endmodule

// File: tb/tb_led_show_controller.sv
// Bench for led_show_controller: a vector table and directed sequences on
// small-prescaler instances, plus random KEY_NEXT/PAUSE/reset traffic checked
// against a step-count reference model.
module tb_led_show_controller;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Main instance: DIV_BITS=2, WIDTH=18, DWELL=4
    logic        a_reset = 1'b1;
    logic        a_key   = 1'b0;
    logic        a_pause = 1'b0;
    logic [17:0] a_ledr;
    logic [1:0]  a_mode;
    logic        a_tick;

    // Long dwell instance: DIV_BITS=2, WIDTH=18, DWELL=40
    logic        b_reset = 1'b1;
    logic        b_key   = 1'b0;
    logic        b_pause = 1'b0;
    logic [17:0] b_ledr;
    logic [1:0]  b_mode;
    logic        b_tick;

    // Narrow instance: DIV_BITS=1, WIDTH=4, DWELL=20
    logic        w_reset = 1'b1;
    logic        w_key   = 1'b0;
    logic        w_pause = 1'b0;
    logic [3:0]  w_ledr;
    logic [1:0]  w_mode;
    logic        w_tick;

    led_show_controller #(.DIV_BITS(2), .WIDTH(18), .DWELL(4)) dut_a (
        .CLOCK_50 (CLOCK_50),
        .reset    (a_reset),
        .KEY_NEXT (a_key),
        .PAUSE    (a_pause),
        .LEDR     (a_ledr),
        .MODE     (a_mode),
        .TICK     (a_tick)
    );

    led_show_controller #(.DIV_BITS(2), .WIDTH(18), .DWELL(40)) dut_b (
        .CLOCK_50 (CLOCK_50),
        .reset    (b_reset),
        .KEY_NEXT (b_key),
        .PAUSE    (b_pause),
        .LEDR     (b_ledr),
        .MODE     (b_mode),
        .TICK     (b_tick)
    );

    led_show_controller #(.DIV_BITS(1), .WIDTH(4), .DWELL(20)) dut_w (
        .CLOCK_50 (CLOCK_50),
        .reset    (w_reset),
        .KEY_NEXT (w_key),
        .PAUSE    (w_pause),
        .LEDR     (w_ledr),
        .MODE     (w_mode),
        .TICK     (w_tick)
    );

    typedef struct {
        logic        rst;
        logic        key;
        logic        pause;
        int          ncyc;
        logic [17:0] ledr;
        logic [1:0]  mode;
        logic        tick;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Expected pattern after k steps in a mode, from the mode rules directly.
    function automatic logic [31:0] pat(input int mode, input int k, input int w);
        logic [31:0] r;
        int          p;
        r = '0;
        case (mode)
            0: begin
                p = k % (2 * (w - 1));
                if (p > w - 1) p = 2 * (w - 1) - p;
                r[p] = 1'b1;
            end
            1: begin
                p = k % (w + 1);
                for (int i = 0; i < p; i++) r[i] = 1'b1;
            end
            2: begin
                for (int i = 0; i < w; i++) r[i] = ((i % 2) == (k % 2));
            end
            default: r = 32'(k % (1 << w));
        endcase
        return r;
    endfunction

    initial begin
        int m_mode;
        int m_k;
        int m_ph;
        bit m_keyprev;
        bit tick_now;
        bit step;
        bit adv;
        logic rst;

        //                rst   key   pause ncyc ledr       mode  tick
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1,  18'h00001, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3,  18'h00001, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1,  18'h00001, 2'd0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1,  18'h00002, 2'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 3,  18'h00002, 2'd0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1,  18'h00004, 2'd0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4,  18'h00008, 2'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 3,  18'h00008, 2'd0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1,  18'h00000, 2'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4,  18'h00000, 2'd1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1,  18'h00001, 2'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4,  18'h00003, 2'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4,  18'h00007, 2'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1,  18'h15555, 2'd2, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 20, 18'h15555, 2'd2, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1,  18'h15555, 2'd2, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1,  18'h00000, 2'd3, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 4,  18'h00000, 2'd3, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1,  18'h00001, 2'd3, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1,  18'h00001, 2'd0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 4,  18'h00001, 2'd0, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1,  18'h00002, 2'd0, 1'b0};

        @(negedge CLOCK_50);
        foreach (vecs[i]) begin
            a_reset = vecs[i].rst;
            a_key   = vecs[i].key;
            a_pause = vecs[i].pause;
            cyc(vecs[i].ncyc);
            check($sformatf("vec%0d LEDR", i), 32'(a_ledr), 32'(vecs[i].ledr));
            check($sformatf("vec%0d MODE", i), 32'(a_mode), 32'(vecs[i].mode));
            check($sformatf("vec%0d TICK", i), 32'(a_tick), 32'(vecs[i].tick));
        end

        // Key edge on the dwell-expiry step: one advance only.
        a_key = 1'b0;
        cyc(11);
        check("collide pre LEDR", 32'(a_ledr), 32'h8);
        check("collide pre TICK", 32'(a_tick), 32'h1);
        a_key = 1'b1;
        cyc(1);
        check("collide MODE", 32'(a_mode), 32'd1);
        check("collide LEDR", 32'(a_ledr), 32'h0);
        a_key = 1'b0;

        // PAUSE across three ticks freezes pattern and dwell.
        cyc(4);
        check("pause pre TICK", 32'(a_tick), 32'h1);
        cyc(1);
        check("pause pre LEDR", 32'(a_ledr), 32'h1);
        a_pause = 1'b1;
        cyc(12);
        check("paused LEDR", 32'(a_ledr), 32'h1);
        check("paused MODE", 32'(a_mode), 32'd1);
        a_pause = 1'b0;
        cyc(4);
        check("unpause LEDR 3", 32'(a_ledr), 32'h3);
        cyc(4);
        check("unpause LEDR 7", 32'(a_ledr), 32'h7);
        cyc(4);
        check("unpause expiry MODE", 32'(a_mode), 32'd2);
        check("unpause expiry LEDR", 32'(a_ledr), 32'h15555);

        // Bounce reversal and mid-operation reset on the DWELL=40 instance.
        cyc(1);
        b_reset = 1'b0;
        cyc(69);
        check("bounce top LEDR", 32'(b_ledr), 32'h20000);
        cyc(4);
        check("bounce back LEDR", 32'(b_ledr), 32'h10000);
        cyc(64);
        check("bounce bottom LEDR", 32'(b_ledr), 32'h1);
        check("bounce bottom MODE", 32'(b_mode), 32'd0);
        cyc(4);
        check("bounce left LEDR", 32'(b_ledr), 32'h2);
        for (int i = 0; i < 3; i++) begin
            b_key = 1'b1;
            cyc(1);
            b_key = 1'b0;
            cyc(1);
        end
        check("b count MODE", 32'(b_mode), 32'd3);
        cyc(20);
        check("b count LEDR", 32'(b_ledr), 32'h5);
        b_reset = 1'b1;
        cyc(1);
        check("midreset LEDR", 32'(b_ledr), 32'h1);
        check("midreset MODE", 32'(b_mode), 32'd0);
        check("midreset TICK", 32'(b_tick), 32'h0);
        b_reset = 1'b0;
        cyc(3);
        check("midreset no early TICK", 32'(b_tick), 32'h0);
        cyc(1);
        check("midreset first TICK", 32'(b_tick), 32'h1);

        // COUNT wrap on the narrow instance.
        w_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_key = 1'b1;
            cyc(1);
            w_key = 1'b0;
            cyc(1);
        end
        cyc(30);
        check("wrap top LEDR", 32'(w_ledr), 32'hF);
        check("wrap top MODE", 32'(w_mode), 32'd3);
        cyc(2);
        check("wrap zero LEDR", 32'(w_ledr), 32'h0);
        check("wrap zero MODE", 32'(w_mode), 32'd3);

        // Random traffic on the narrow instance against the step-count model.
        w_reset = 1'b1;
        w_key   = 1'b0;
        w_pause = 1'b0;
        cyc(1);
        m_mode = 0; m_k = 0; m_ph = 0; m_keyprev = 1'b0;
        w_reset = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) w_key = ~w_key;
            if ($urandom_range(0, 19) == 0) w_pause = ~w_pause;
            w_reset = rst;
            tick_now = (m_ph > 0) && (m_ph % 2 == 0);
            if (rst) begin
                m_mode = 0; m_k = 0; m_ph = 0; m_keyprev = 1'b0;
            end else begin
                step = tick_now && !w_pause;
                adv  = (w_key && !m_keyprev) || (step && m_k == 19);
                if (adv) begin
                    m_mode = (m_mode + 1) % 4;
                    m_k    = 0;
                    m_ph   = 0;
                end else begin
                    m_ph++;
                    if (step) m_k++;
                end
                m_keyprev = w_key;
            end
            cyc(1);
            check($sformatf("rand%0d LEDR", n), 32'(w_ledr), pat(m_mode, m_k, 4));
            check($sformatf("rand%0d MODE", n), 32'(w_mode), 32'(m_mode));
            check($sformatf("rand%0d TICK", n), 32'(w_tick),
                  32'((m_ph > 0) && (m_ph % 2 == 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
